impulse_capture_avg: RTL

//  Parametrised impulse-response capture engine. Fires a test impulse, waits a programmable

---
 rtl/impulse_capture_pkg.sv | 20 ++
 rtl/ir_accum_ram.sv | 22 ++
 rtl/impulse_capture_avg.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/impulse_capture_pkg.sv
// Shared types and constant helpers for the impulse-response capture engine.
package impulse_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    DELAY,
    CAPTURE,
    SETTLE
  } capture_state_t;

  function automatic int acc_width(input int sample_width, input int num_averages);
    return sample_width + $clog2(num_averages);
  endfunction

  function automatic logic [63:0] full_scale(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/ir_accum_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
module ir_accum_ram #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/impulse_capture_avg.sv
// Impulse-response capture with coherent averaging over NUM_AVERAGES passes.
// Optional peak tracker enabled by defining IMPULSE_CAPTURE_PEAK_EN.
module impulse_capture_avg
  import impulse_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int IMPULSE_LENGTH  = 48000,
  parameter int NUM_AVERAGES    = 4,
  parameter int IMPULSE_SAMPLES = 4,
  parameter int SETTLE_SAMPLES  = 4800
) (
  input  logic                              audio_clk,
  input  logic                              rst_in,
  input  logic                              audio_trigger,
  input  logic signed [SAMPLE_WIDTH-1:0]    audio_in,
  input  logic                              start_in,
  input  logic                              abort_in,
  input  logic [15:0]                       delay_length,
  output logic signed [SAMPLE_WIDTH-1:0]    impulse_amp_out,
  output logic                              busy_out,
  output logic                              impulse_recorded,
  output logic [7:0]                        pass_out,
  input  logic [$clog2(IMPULSE_LENGTH)-1:0] rd_addr,
  output logic signed [SAMPLE_WIDTH-1:0]    rd_data
`ifdef IMPULSE_CAPTURE_PEAK_EN
  ,
  output logic [SAMPLE_WIDTH-1:0]           peak_mag_out,
  output logic [$clog2(IMPULSE_LENGTH)-1:0] peak_idx_out
`endif
);

  localparam int AW    = $clog2(IMPULSE_LENGTH);
  localparam int SH    = $clog2(NUM_AVERAGES);
  localparam int ACC_W = acc_width(SAMPLE_WIDTH, NUM_AVERAGES);
  localparam logic [SAMPLE_WIDTH-1:0] FULL_SCALE = SAMPLE_WIDTH'(full_scale(SAMPLE_WIDTH));

  capture_state_t r_state, w_state_next;
  logic [31:0] r_cnt;
  logic [15:0] r_delay;
  logic [7:0]  r_pass;
  logic        r_busy, r_recorded;
  logic        w_cnt_clr, w_cnt_inc, w_start, w_cap, w_pass_inc, w_done, w_last_pass;

  assign w_last_pass = (r_pass == 8'(NUM_AVERAGES - 1));

  always_ff @(posedge audio_clk) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_start      = 1'b0;
    w_cap        = 1'b0;
    w_pass_inc   = 1'b0;
    w_done       = 1'b0;
    if (abort_in) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start_in) begin
          w_state_next = FIRE;
          w_start      = 1'b1;
          w_cnt_clr    = 1'b1;
        end
        FIRE: if (audio_trigger) begin
          if (r_cnt == 32'(IMPULSE_SAMPLES - 1)) begin
            w_cnt_clr    = 1'b1;
            w_state_next = (r_delay == 16'd0) ? CAPTURE : DELAY;
          end else w_cnt_inc = 1'b1;
        end
        DELAY: if (audio_trigger) begin
          if (r_cnt == {16'd0, r_delay} - 32'd1) begin
            w_cnt_clr    = 1'b1;
            w_state_next = CAPTURE;
          end else w_cnt_inc = 1'b1;
        end
        CAPTURE: if (audio_trigger) begin
          w_cap = 1'b1;
          if (r_cnt == 32'(IMPULSE_LENGTH - 1)) begin
            w_cnt_clr = 1'b1;
            if (w_last_pass) begin
              w_done       = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_pass_inc   = 1'b1;
              w_state_next = (SETTLE_SAMPLES == 0) ? FIRE : SETTLE;
            end
          end else w_cnt_inc = 1'b1;
        end
        SETTLE: if (audio_trigger) begin
          if (r_cnt == 32'(SETTLE_SAMPLES - 1)) begin
            w_cnt_clr    = 1'b1;
            w_state_next = FIRE;
          end else w_cnt_inc = 1'b1;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge audio_clk) begin
    if (!rst_in) begin
      r_cnt      <= '0;
      r_delay    <= '0;
      r_pass     <= '0;
      r_busy     <= 1'b0;
      r_recorded <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 32'd1;
      if (abort_in) begin
        r_busy     <= 1'b0;
        r_recorded <= 1'b0;
      end else if (w_start) begin
        r_busy     <= 1'b1;
        r_recorded <= 1'b0;
        r_pass     <= '0;
        r_delay    <= delay_length;
      end else if (w_done) begin
        r_busy     <= 1'b0;
        r_recorded <= 1'b1;
      end else if (w_pass_inc) begin
        r_pass <= r_pass + 8'd1;
      end
    end
  end

  // Read-modify-write: RAM read on the trigger cycle, sum next cycle, write the cycle after.
  logic                     r_s1_vld, r_s1_first, r_s2_vld;
  logic [AW-1:0]            r_s1_addr, r_s2_addr;
  logic signed [SAMPLE_WIDTH-1:0] r_s1_sample;
  logic signed [ACC_W-1:0]  r_s2_data, w_sample_ext, w_sum, w_ram_rdata;
  logic [AW-1:0]            w_raddr;
  logic                     w_we;

  assign w_sample_ext = ACC_W'(r_s1_sample);
  assign w_sum        = r_s1_first ? w_sample_ext : (w_ram_rdata + w_sample_ext);
  assign w_we         = r_s2_vld & ~abort_in & rst_in;
  assign w_raddr      = r_busy ? r_cnt[AW-1:0] : rd_addr;

  always_ff @(posedge audio_clk) begin
    if (!rst_in || abort_in) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_cap;
      r_s2_vld <= r_s1_vld;
    end
    r_s1_addr   <= r_cnt[AW-1:0];
    r_s1_sample <= audio_in;
    r_s1_first  <= (r_pass == 8'd0);
    r_s2_addr   <= r_s1_addr;
    r_s2_data   <= w_sum;
  end

  ir_accum_ram #(
    .WIDTH (ACC_W),
    .DEPTH (IMPULSE_LENGTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (audio_clk),
    .i_we    (w_we),
    .i_waddr (r_s2_addr),
    .i_wdata (r_s2_data),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  logic                           r_rd_oob;
  logic signed [SAMPLE_WIDTH-1:0] r_rd_data;

  always_ff @(posedge audio_clk) begin
    if (!rst_in) begin
      r_rd_oob  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_oob  <= ({1'b0, rd_addr} >= (AW + 1)'(IMPULSE_LENGTH));
      r_rd_data <= r_rd_oob ? '0 : SAMPLE_WIDTH'(w_ram_rdata >>> SH);
    end
  end

  assign rd_data          = r_busy ? '0 : r_rd_data;
  assign impulse_amp_out  = (r_state == FIRE) ? FULL_SCALE : '0;
  assign busy_out         = r_busy;
  assign impulse_recorded = r_recorded;
  assign pass_out         = r_pass;

`ifdef IMPULSE_CAPTURE_PEAK_EN
  logic             r_s1_last, r_s2_last;
  logic [ACC_W-1:0] r_peak_mag, w_abs;
  logic [AW-1:0]    r_peak_idx;

  assign w_abs = r_s2_data[ACC_W-1] ? ACC_W'(-r_s2_data) : ACC_W'(r_s2_data);

  // Strict compare keeps the earliest index on ties.
  always_ff @(posedge audio_clk) begin
    r_s1_last <= w_last_pass;
    r_s2_last <= r_s1_last;
    if (!rst_in || w_start) begin
      r_peak_mag <= '0;
      r_peak_idx <= '0;
    end else if (w_we && r_s2_last && (w_abs > r_peak_mag)) begin
      r_peak_mag <= w_abs;
      r_peak_idx <= r_s2_addr;
    end
  end

  assign peak_mag_out = r_recorded ? SAMPLE_WIDTH'(r_peak_mag >> SH) : '0;
  assign peak_idx_out = r_recorded ? r_peak_idx : '0;
`endif

endmodule
